// File: rtl/pattern_rom_arbiter.sv
// rtl/pattern_rom_arbiter.sv - two-requester arbiter for the single-port pattern ROM
// Grants whole bursts, alternates owners on ties, pre-empts long holders, tags reads for return.
module pattern_rom_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 38,
  parameter int ROM_LAT  = 1,
  parameter int MAX_HOLD = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_oe,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_oe,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rom_oe,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_p_Data,
  output logic              viol
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, HANDOVER} state_t;

  state_t              state;
  logic                last_owner;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [ROM_LAT-1:0]  tag0;
  logic [ROM_LAT-1:0]  tag1;

  logic acc0, acc1;
  logic any_req, pick1;
  logic owner_req, other_req, hold_hit;

  always_comb begin
    acc0      = r0_gnt & r0_oe;
    acc1      = r1_gnt & r1_oe;
    rom_oe    = acc0 | acc1;
    rom_addr  = r0_gnt ? r0_addr : (r1_gnt ? r1_addr : '0);
    rd_data   = rom_p_Data;
    r0_rvalid = tag0[ROM_LAT-1];
    r1_rvalid = tag1[ROM_LAT-1];
  end

  // On a tie the requester that did not own the ROM last wins.
  always_comb begin
    any_req   = r0_req | r1_req;
    pick1     = r1_req & (~r0_req | ~last_owner);
    owner_req = (state == GNT0) ? r0_req : r1_req;
    other_req = (state == GNT0) ? r1_req : r0_req;
    hold_hit  = other_req & (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE, HANDOVER: begin
          hold_cnt <= '0;
          if (!any_req) begin
            state  <= IDLE;
            r0_gnt <= 1'b0;
            r1_gnt <= 1'b0;
          end else if (pick1) begin
            state  <= GNT1;
            r0_gnt <= 1'b0;
            r1_gnt <= 1'b1;
          end else begin
            state  <= GNT0;
            r0_gnt <= 1'b1;
            r1_gnt <= 1'b0;
          end
        end
        GNT0, GNT1: begin
          // Release or forced revoke both pass through one dead cycle.
          if (!owner_req || hold_hit) begin
            state      <= HANDOVER;
            r0_gnt     <= 1'b0;
            r1_gnt     <= 1'b0;
            last_owner <= (state == GNT1);
            hold_cnt   <= '0;
          end else if (other_req) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else begin
            hold_cnt <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          r0_gnt <= 1'b0;
          r1_gnt <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (ROM_LAT == 1) begin : g_tag_lat1
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tag0 <= '0;
          tag1 <= '0;
        end else begin
          tag0 <= acc0;
          tag1 <= acc1;
        end
      end
    end else begin : g_tag_latn
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tag0 <= '0;
          tag1 <= '0;
        end else begin
          tag0 <= {tag0[ROM_LAT-2:0], acc0};
          tag1 <= {tag1[ROM_LAT-2:0], acc1};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      viol <= 1'b0;
    end else begin
      viol <= viol | (r0_oe & ~r0_gnt) | (r1_oe & ~r1_gnt);
    end
  end

endmodule

// File: tb/tb_pattern_rom_arbiter.sv
// tb/tb_pattern_rom_arbiter.sv - self-checking bench for pattern_rom_arbiter
// Table vectors, directed corner sequences and a random run against an owner/queue model.
module tb_pattern_rom_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 38;
  localparam int MAX_HOLD = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              r0_req, r0_oe, r1_req, r1_oe;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic              r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DATA_W-1:0] rd_data;
  logic              rom_oe;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_p_Data;
  logic              viol;

  always #5 clk = ~clk;

  pattern_rom_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_oe(r0_oe), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_oe(r1_oe), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rd_data(rd_data), .rom_oe(rom_oe), .rom_addr(rom_addr), .rom_p_Data(rom_p_Data),
    .viol(viol)
  );

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] a);
    return {a[5:0], a ^ 8'hA5, ~a, a, a + 8'd77};
  endfunction

  always @(posedge clk) if (rom_oe) rom_p_Data <= pat(rom_addr);

  int checks = 0;
  int failures = 0;

  // Model: who owns the ROM (-1 = nobody), who owned it last, how long the other has waited,
  // and the single read in flight.
  int         m_owner, m_last, m_hold;
  bit         m_viol, m_rv0, m_rv1;
  logic [7:0] m_raddr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_hold = 0;
    m_viol = 0; m_rv0 = 0; m_rv1 = 0; m_raddr = '0;
  endtask

  function automatic bit exp_oe();
    return (m_owner == 0 && r0_oe) || (m_owner == 1 && r1_oe);
  endfunction

  function automatic logic [7:0] exp_addr();
    if (m_owner == 0) return r0_addr;
    if (m_owner == 1) return r1_addr;
    return 8'h00;
  endfunction

  task automatic model_step();
    bit         n_rv0, n_rv1, sreq, oreq;
    logic [7:0] n_addr;
    n_rv0  = (m_owner == 0) && r0_oe;
    n_rv1  = (m_owner == 1) && r1_oe;
    n_addr = exp_addr();
    if ((r0_oe && m_owner != 0) || (r1_oe && m_owner != 1)) m_viol = 1;
    if (m_owner >= 0) begin
      sreq = (m_owner == 0) ? r0_req : r1_req;
      oreq = (m_owner == 0) ? r1_req : r0_req;
      if (!sreq || (oreq && m_hold == MAX_HOLD - 1)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold = oreq ? m_hold + 1 : 0;
      end
    end else begin
      if (r0_req && r1_req) m_owner = 1 - m_last;
      else if (r0_req)      m_owner = 0;
      else if (r1_req)      m_owner = 1;
      else                  m_owner = -1;
      m_hold = 0;
    end
    m_rv0 = n_rv0; m_rv1 = n_rv1; m_raddr = n_addr;
  endtask

  task automatic check_outputs();
    chk("r0_gnt", r0_gnt, m_owner == 0);
    chk("r1_gnt", r1_gnt, m_owner == 1);
    chk("rom_oe", rom_oe, exp_oe());
    chk("rom_addr", rom_addr, exp_addr());
    chk("r0_rvalid", r0_rvalid, m_rv0);
    chk("r1_rvalid", r1_rvalid, m_rv1);
    chk("viol", viol, m_viol);
    if (m_rv0 || m_rv1) chk("rd_data", rd_data, pat(m_raddr));
  endtask

  // Called at the negedge: compare, advance the model, move to just after the next posedge.
  task automatic finish_cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit q0, input bit o0, input logic [7:0] a0,
                       input bit q1, input bit o1, input logic [7:0] a1);
    r0_req = q0; r0_oe = o0; r0_addr = a0;
    r1_req = q1; r1_oe = o1; r1_addr = a1;
  endtask

  task automatic cycle(input bit q0, input bit o0, input logic [7:0] a0,
                       input bit q1, input bit o1, input logic [7:0] a1);
    drive(q0, o0, a0, q1, o1, a1);
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    bit q0, o0; logic [7:0] a0;
    bit q1, o1; logic [7:0] a1;
    bit g0, g1, oe; logic [7:0] addr;
    bit rv0, rv1, vl;
  } vec_t;

  function automatic vec_t mk(bit q0, bit o0, logic [7:0] a0, bit q1, bit o1, logic [7:0] a1,
                              bit g0, bit g1, bit oe, logic [7:0] addr, bit rv0, bit rv1, bit vl);
    vec_t v;
    v.q0 = q0; v.o0 = o0; v.a0 = a0; v.q1 = q1; v.o1 = o1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.oe = oe; v.addr = addr; v.rv0 = rv0; v.rv1 = rv1; v.vl = vl;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    int n1, gap, nrv0, nrv1, guard;
    bit done;

    rom_p_Data = '0;
    tbl[0]  = mk(1,0,8'd0, 1,0,8'd0,   0,0,0,8'd0,  0,0,0);
    tbl[1]  = mk(1,1,8'd10,1,0,8'd0,   1,0,1,8'd10, 0,0,0);
    tbl[2]  = mk(0,1,8'd11,1,0,8'd0,   1,0,1,8'd11, 1,0,0);
    tbl[3]  = mk(0,0,8'd0, 1,0,8'd0,   0,0,0,8'd0,  1,0,0);
    tbl[4]  = mk(0,0,8'd0, 1,1,8'd20,  0,1,1,8'd20, 0,0,0);
    tbl[5]  = mk(0,0,8'd0, 0,0,8'd0,   0,1,0,8'd0,  0,1,0);
    tbl[6]  = mk(0,0,8'd0, 0,0,8'd0,   0,0,0,8'd0,  0,0,0);
    tbl[7]  = mk(1,0,8'd0, 1,0,8'd0,   0,0,0,8'd0,  0,0,0);
    tbl[8]  = mk(0,0,8'd0, 0,0,8'd0,   1,0,0,8'd0,  0,0,0);
    tbl[9]  = mk(1,0,8'd0, 1,0,8'd0,   0,0,0,8'd0,  0,0,0);
    tbl[10] = mk(1,0,8'd0, 1,1,8'd33,  0,1,1,8'd33, 0,0,0);
    tbl[11] = mk(1,0,8'd0, 0,0,8'd0,   0,1,0,8'd0,  0,1,0);
    tbl[12] = mk(1,0,8'd0, 0,0,8'd0,   0,0,0,8'd0,  0,0,0);
    tbl[13] = mk(0,0,8'd0, 0,0,8'd0,   1,0,0,8'd0,  0,0,0);
    tbl[14] = mk(0,0,8'd0, 0,0,8'd0,   0,0,0,8'd0,  0,0,0);

    // Reset state, with requests and strobes asserted while reset is held
    reset = 1'b0;
    model_reset();
    drive(1, 1, 8'h12, 1, 1, 8'h34);
    repeat (3) @(negedge clk);
    chk("rst_r0_gnt", r0_gnt, 0);
    chk("rst_r1_gnt", r1_gnt, 0);
    chk("rst_rom_oe", rom_oe, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rst_viol", viol, 0);
    do_reset();

    // Tie/alternation table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].q0, tbl[i].o0, tbl[i].a0, tbl[i].q1, tbl[i].o1, tbl[i].a1);
      @(negedge clk);
      chk($sformatf("tbl%0d_g0", i), r0_gnt, tbl[i].g0);
      chk($sformatf("tbl%0d_g1", i), r1_gnt, tbl[i].g1);
      chk($sformatf("tbl%0d_oe", i), rom_oe, tbl[i].oe);
      chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_rv0", i), r0_rvalid, tbl[i].rv0);
      chk($sformatf("tbl%0d_rv1", i), r1_rvalid, tbl[i].rv1);
      chk($sformatf("tbl%0d_viol", i), viol, tbl[i].vl);
      finish_cycle();
    end

    // 31-read loader burst, last oe issued together with the release
    do_reset();
    cycle(1, 0, 8'd0, 0, 0, 8'd0);
    nrv0 = 0; nrv1 = 0;
    for (int i = 0; i < 31; i++) begin
      drive(i != 30, 1, 8'(30 + i), 0, 0, 8'd0);
      @(negedge clk);
      chk("burst_gnt", r0_gnt, 1);
      chk("burst_addr", rom_addr, 8'(30 + i));
      if (r0_rvalid) nrv0++;
      if (r1_rvalid) nrv1++;
      finish_cycle();
    end
    drive(0, 0, 8'd0, 0, 0, 8'd0);
    @(negedge clk);
    chk("handover_rvalid", r0_rvalid, 1);
    chk("handover_oe", rom_oe, 0);
    chk("handover_gnt", {r0_gnt, r1_gnt}, 0);
    if (r0_rvalid) nrv0++;
    if (r1_rvalid) nrv1++;
    finish_cycle();
    chk("burst_r0_rvalid_count", nrv0, 31);
    chk("burst_r1_rvalid_count", nrv1, 0);

    // Pre-emption of r1 by a waiting r0, then r1 re-granted
    cycle(0, 0, 8'd0, 1, 0, 8'd0);
    n1 = 0; gap = 0; done = 0;
    for (guard = 0; guard < 100 && !done; guard++) begin
      drive(1, m_owner == 0, 8'h40, 1, m_owner == 1, 8'(guard));
      @(negedge clk);
      done = r0_gnt;
      if (!done) begin
        if (r1_gnt) n1++;
        else gap++;
      end
      finish_cycle();
    end
    chk("preempt_reached", done, 1);
    chk("preempt_hold_cycles", n1, MAX_HOLD);
    chk("preempt_gap", gap, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 8'(8'h50 + i), 1, 0, 8'd0);
    gap = 0; done = 0;
    for (guard = 0; guard < 20 && !done; guard++) begin
      drive(0, 0, 8'd0, 1, 0, 8'd0);
      @(negedge clk);
      done = r1_gnt;
      if (!r0_gnt && !r1_gnt) gap++;
      finish_cycle();
    end
    chk("regrant_reached", done, 1);
    chk("regrant_gap", gap, 1);
    cycle(0, 0, 8'd0, 0, 0, 8'd0);
    cycle(0, 0, 8'd0, 0, 0, 8'd0);

    // Non-owner strobe
    drive(0, 0, 8'd0, 0, 1, 8'h77);
    @(negedge clk);
    chk("viol_rom_oe", rom_oe, 0);
    finish_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'd0, 0, 0, 8'd0);
      @(negedge clk);
      chk("viol_sticky", viol, 1);
      chk("viol_no_rvalid", r1_rvalid, 0);
      finish_cycle();
    end

    // Reset mid-burst
    cycle(1, 0, 8'd0, 0, 0, 8'd0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 8'(8'h60 + i), 0, 0, 8'd0);
    #1 reset = 1'b0;
    #1;
    chk("midrst_gnt", {r0_gnt, r1_gnt}, 0);
    chk("midrst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("midrst_rom_oe", rom_oe, 0);
    chk("midrst_viol", viol, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_hold", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rom_oe, viol}, 0);
    end
    model_reset();
    drive(0, 0, 8'd0, 0, 0, 8'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1, 0, 8'd0, 1, 0, 8'd0);
    drive(1, 0, 8'd0, 1, 0, 8'd0);
    @(negedge clk);
    chk("tie_after_reset", {r0_gnt, r1_gnt}, 2'b10);
    finish_cycle();
    cycle(0, 0, 8'd0, 0, 0, 8'd0);
    cycle(0, 0, 8'd0, 0, 0, 8'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit q0, q1;
      q0 = ($urandom_range(0, 15) == 0) ? ~r0_req : r0_req;
      q1 = ($urandom_range(0, 15) == 0) ? ~r1_req : r1_req;
      drive(q0, (m_owner == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 299) == 0),
            8'($urandom_range(0, 255)),
            q1, (m_owner == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 299) == 0),
            8'($urandom_range(0, 255)));
      @(negedge clk);
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
